mod5_seq_monitor: RTL
=====================

Name: mod5_seq_monitor

Overview:
- Downstream consumer of the mod-5 synchronous counter's 3-bit state bus Q.
- Decodes the count into a registered one-hot 5-phase strobe and a wrap pulse (divide-by-5 tick).
- Tracks completed cycles and checks that the counter only walks 0→1→2→3→4→0.
- Flags illegal codes (5, 6, 7) and out-of-sequence steps, and holds a lock/error status for the system.

Parameters:
- CNT_W, 8, width of the wrap counter `wraps`.
- LOCK_WRAPS, 2, number of consecutive clean 4→0 wraps required before `locked` asserts (range 1..15).

Ports:
- `CLK`  input  1  clock; all state updates on posedge. The upstream counter changes Q on negedge, so Q is stable at the sample point.
- `rst`  input  1  synchronous, active-low reset (0 = reset, sampled on posedge `CLK`).
- `Q`  input  3  counter state, Q[2] MSB; legal values 0..4.
- `err_clr`  input  1  single-cycle pulse that clears error state and returns the block to SYNC.
- `phase`  output  5  one-hot, phase[k]=1 when the sampled Q==k; all zero for an illegal code.
- `wrap`  output  1  one-cycle pulse on a legal 4→0 transition.
- `wraps`  output  CNT_W  count of legal 4→0 transitions, wraps modulo 2^CNT_W.
- `locked`  output  1  high in state LOCKED.
- `err_illegal`  output  1  sticky flag: a code >4 was seen.
- `err_seq`  output  1  sticky flag: a legal but out-of-order step was seen.

Behaviour:
- Reset (`rst`==0 at posedge): `phase`=0, `wrap`=0, `wraps`=0, `locked`=0, both error flags 0, history invalid, state=SYNC, clean-wrap counter=0. Reset wins over every other input.
- Input handling: Q is registered into `q_s` each cycle. All decode and checks run on `q_s` against the previous sample `q_p`.
- Latency:
  - Q→`phase` is 2 posedges: sample, then registered decode.
  - `wrap` and the error flags update on the same edge as `phase`.
- History: the first valid sample after reset or `err_clr` only loads `q_p`. No sequence check is made on it.
- Expected next value: nxt = (q_p==4) ? 0 : q_p+1.
- Illegal code (q_s>4):
  - sets `err_illegal`, `phase`=0, state→ERROR.
  - no sequence check and no wrap.
- Sequence error: q_s legal, history valid, q_s≠nxt (and not an allowed hold) → sets `err_seq`, state→ERROR.
- Legal wrap: q_p==4 and q_s==0 → `wrap`=1 for one cycle and `wraps`+1. The counter rolls over silently at 2^CNT_W.
- FSM:
  - SYNC: wait for a legal 4→0 wrap.
    - On each clean wrap, the clean-wrap counter +1.
    - When it reaches LOCKED_WRAPS → LOCKED (i.e. the counter reaches LOCK_WRAPS).
    - Any error → ERROR and the clean-wrap counter is cleared.
  - LOCKED: `locked`=1. Any error → ERROR.
  - ERROR: `locked`=0. `phase`, `wrap` and `wraps` keep tracking legal steps; the flags stay set.
    - `err_clr` → SYNC, clears both flags and the clean-wrap counter, and invalidates history.
- `err_clr` outside ERROR: clears the flags, no state change.
- `err_clr` on the same cycle as a new error: the new error wins (flag set, state ERROR).
- Reset mid-operation: returns to the reset values on that edge. Monitoring restarts with history invalid.
- Simultaneous illegal code and `err_clr`: the illegal code wins.

Optional Feature:
- Macro `MOD5_MON_HOLD_EN`.
- Defined: q_s==q_p (counter held or stalled) is a legal step.
  - No `err_seq`, no wrap, `phase` unchanged, state unchanged.
  - Additional output `hold` (1 bit): one-cycle pulse for each held cycle.
- Not defined: a repeated value is a sequence error. The `hold` port does not exist.

Test Plan:
- Reset, then free-running Q 0,1,2,3,4,0,1,2,3,4,0 (one per clock):
  - `phase` walks 00001→10000 with 2-cycle latency.
  - `wrap` pulses twice, `wraps`=2, `locked`=1 after the 2nd wrap.
  - error flags stay 0.
- While locked, drive Q=6 for one cycle, then resume 0..4:
  - `err_illegal`=1 and `phase`=00000 for that sample, `locked`=0, state ERROR.
  - afterwards `wraps` still increments.
  - `err_clr` then two clean wraps → `locked`=1 and flags 0.
- Sequence skip 0,1,3 while locked → `err_seq`=1, `locked`=0, `err_illegal`=0.
- Hold of Q=2 for 3 cycles:
  - without `MOD5_MON_HOLD_EN`: `err_seq`=1.
  - with it: no error, `hold` pulses 2 times, `locked` unchanged.
- Assert `rst`=0 mid-sequence at Q=3:
  - next edge gives all outputs 0 and `wraps`=0.
  - after release, the first sample raises no `err_seq` even though the step is not 3→4.
- CNT_W=2, run 5 full cycles → `wraps` reads 1 after rolling over 3→0.

Source files
------------

// File: rtl/mod5_seq_monitor.sv
// Monitor for a mod-5 counter state bus: one-hot phase decode, wrap tick/count,
// illegal/sequence checking and lock status. Optional `MOD5_MON_HOLD_EN accepts held counts.
//
// state    | meaning
// S_SYNC   | counting clean 4->0 wraps toward lock
// S_LOCKED | LOCK_WRAPS clean wraps seen, no error since
// S_ERROR  | error seen; waits for err_clr
module mod5_seq_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_WRAPS = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [2:0]       Q,
  input  logic             err_clr,
  output logic [4:0]       phase,
  output logic             wrap,
  output logic [CNT_W-1:0] wraps,
  output logic             locked,
  output logic             err_illegal,
`ifdef MOD5_MON_HOLD_EN
  output logic             hold,
`endif
  output logic             err_seq
);

  typedef enum logic [1:0] {S_SYNC, S_LOCKED, S_ERROR} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_WRAPS);

  state_t           state_q, state_d;
  logic [2:0]       q_s_q, q_s_d;
  logic             s_vld_q, s_vld_d;
  logic [2:0]       q_p_q, q_p_d;
  logic             p_vld_q, p_vld_d;
  logic [3:0]       clean_q, clean_d;
  logic [4:0]       phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] wraps_q, wraps_d;
  logic             locked_q, locked_d;
  logic             ei_q, ei_d;
  logic             es_q, es_d;
  logic             hold_q, hold_d;

  logic       illegal, legal, checked, is_hold, seq_bad, new_err;
  logic [2:0] nxt;

  always_comb begin
    q_s_d   = Q;
    s_vld_d = 1'b1;

    illegal = s_vld_q && (q_s_q > 3'd4);
    legal   = s_vld_q && !illegal;
    checked = legal && p_vld_q;
    nxt     = (q_p_q == 3'd4) ? 3'd0 : q_p_q + 3'd1;
`ifdef MOD5_MON_HOLD_EN
    is_hold = checked && (q_s_q == q_p_q);
`else
    is_hold = 1'b0;
`endif
    seq_bad = checked && !is_hold && (q_s_q != nxt);
    new_err = illegal || seq_bad;

    hold_d  = is_hold;
    wrap_d  = checked && (q_p_q == 3'd4) && (q_s_q == 3'd0);
    wraps_d = wraps_q + CNT_W'(wrap_d);

    phase_d = phase_q;
    if (s_vld_q) phase_d = illegal ? 5'd0 : (5'd1 << q_s_q);

    // a new error in the same cycle as err_clr leaves its flag set
    ei_d = (err_clr ? 1'b0 : ei_q) | illegal;
    es_d = (err_clr ? 1'b0 : es_q) | seq_bad;

    // an illegal code breaks the history so the next legal code only re-anchors
    q_p_d   = legal ? q_s_q : q_p_q;
    p_vld_d = illegal ? 1'b0 : (legal ? 1'b1 : p_vld_q);

    state_d = state_q;
    clean_d = clean_q;
    case (state_q)
      S_SYNC: begin
        if (new_err) begin
          state_d = S_ERROR;
          clean_d = 4'd0;
        end else if (wrap_d) begin
          if (clean_q + 4'd1 >= LOCK_N) begin
            state_d = S_LOCKED;
            clean_d = 4'd0;
          end else begin
            clean_d = clean_q + 4'd1;
          end
        end
      end
      S_LOCKED: begin
        if (new_err) state_d = S_ERROR;
      end
      default: begin
        if (err_clr && !new_err) begin
          state_d = S_SYNC;
          clean_d = 4'd0;
          p_vld_d = 1'b0;
        end
      end
    endcase
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q  <= S_SYNC;
      q_s_q    <= 3'd0;
      s_vld_q  <= 1'b0;
      q_p_q    <= 3'd0;
      p_vld_q  <= 1'b0;
      clean_q  <= 4'd0;
      phase_q  <= 5'd0;
      wrap_q   <= 1'b0;
      wraps_q  <= '0;
      locked_q <= 1'b0;
      ei_q     <= 1'b0;
      es_q     <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_s_q    <= q_s_d;
      s_vld_q  <= s_vld_d;
      q_p_q    <= q_p_d;
      p_vld_q  <= p_vld_d;
      clean_q  <= clean_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      wraps_q  <= wraps_d;
      locked_q <= locked_d;
      ei_q     <= ei_d;
      es_q     <= es_d;
      hold_q   <= hold_d;
    end
  end

  assign phase       = phase_q;
  assign wrap        = wrap_q;
  assign wraps       = wraps_q;
  assign locked      = locked_q;
  assign err_illegal = ei_q;
  assign err_seq     = es_q;
`ifdef MOD5_MON_HOLD_EN
  assign hold        = hold_q;
`else
  logic unused_hold;
  assign unused_hold = hold_q;
`endif

endmodule
